// File: rtl/serial_cmp_pkg.sv
// Shared definitions for the bit-serial comparison interface: stream FSM states
// and the width of beat counters. Reused by the serial receivers.
package serial_cmp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Width needed to hold a beat count in 0..n inclusive.
  function automatic int count_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/serial_shift_reg.sv
// Loadable operand shift register that presents one bit per beat at its head.
// The head is bit N-1 when MSB_FIRST is set, bit 0 otherwise.
module serial_shift_reg #(
  parameter int N         = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load_i,
  input  logic [N-1:0] data_i,
  input  logic         shift_i,
  output logic         head_o
);

  logic [N-1:0] data_q;

  // NOTE: clocked state uses non-blocking assignments only, so every register
  // samples pre-edge values. The data register is reset too: it is only N
  // flops, and a known value keeps the head bit clean after reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      data_q <= '0;
    end else if (load_i) begin
      data_q <= data_i;
    end else if (shift_i) begin
      data_q <= MSB_FIRST ? (data_q << 1) : (data_q >> 1);
    end
  end

  assign head_o = MSB_FIRST ? data_q[N-1] : data_q[0];

endmodule

// File: rtl/serial_operand_tx.sv
// Transmit side of the bit-serial comparison interface: accepts an operand pair,
// streams both operands one bit per beat with first/last framing and reports the count.
module serial_operand_tx
  import serial_cmp_pkg::*;
#(
  parameter int  N         = 8,
  parameter bit  MSB_FIRST = 1'b1,
  localparam int CW        = count_width(N)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  a_in,
  input  logic [N-1:0]  b_in,
  output logic          ser_valid,
  output logic          ser_a,
  output logic          ser_b,
  output logic          ser_first,
  output logic          ser_last,
  input  logic          ser_stall,
  input  logic          ser_stop,
  output logic          done,
  output logic [CW-1:0] bits_sent,
  output logic          busy
);

  state_e        state_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] bits_sent_q;
  logic          in_ready_q;
  logic          ser_valid_q;
  logic          ser_first_q;
  logic          ser_last_q;
  logic          done_q;
  logic          busy_q;

  logic          head_a;
  logic          head_b;
  logic          accept;
  logic          transfer;
  logic [CW-1:0] count_inc;

  assign accept    = (state_q == IDLE) && in_valid;
  assign transfer  = (state_q == SHIFT) && !ser_stall;
  assign count_inc = count_q + CW'(1);

  serial_shift_reg #(.N(N), .MSB_FIRST(MSB_FIRST)) u_shift_a (
    .clock   (clock),
    .reset   (reset),
    .load_i  (accept),
    .data_i  (a_in),
    .shift_i (transfer),
    .head_o  (head_a)
  );

  serial_shift_reg #(.N(N), .MSB_FIRST(MSB_FIRST)) u_shift_b (
    .clock   (clock),
    .reset   (reset),
    .load_i  (accept),
    .data_i  (b_in),
    .shift_i (transfer),
    .head_o  (head_b)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      ser_valid_q <= 1'b0;
      ser_first_q <= 1'b0;
      ser_last_q  <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      count_q     <= '0;
      bits_sent_q <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            state_q     <= SHIFT;
            in_ready_q  <= 1'b0;
            ser_valid_q <= 1'b1;
            ser_first_q <= 1'b1;
            ser_last_q  <= (N == 1);
            busy_q      <= 1'b1;
            count_q     <= '0;
            bits_sent_q <= '0;
          end
        end
        SHIFT: begin
          // A stop ends the stream at once; the presented beat counts only if it
          // also transferred at this edge.
          if (ser_stop || (transfer && ser_last_q)) begin
            state_q     <= DONE;
            ser_valid_q <= 1'b0;
            ser_first_q <= 1'b0;
            ser_last_q  <= 1'b0;
            done_q      <= 1'b1;
            count_q     <= transfer ? count_inc : count_q;
            bits_sent_q <= transfer ? count_inc : count_q;
          end else if (transfer) begin
            count_q     <= count_inc;
            ser_first_q <= 1'b0;
            ser_last_q  <= (count_inc == CW'(N - 1));
          end
        end
        DONE: begin
          state_q    <= IDLE;
          in_ready_q <= 1'b1;
          busy_q     <= 1'b0;
        end
        default: begin
          state_q    <= IDLE;
          in_ready_q <= 1'b1;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign ser_valid = ser_valid_q;
  assign ser_a     = ser_valid_q & head_a;
  assign ser_b     = ser_valid_q & head_b;
  assign ser_first = ser_first_q;
  assign ser_last  = ser_last_q;
  assign done      = done_q;
  assign bits_sent = bits_sent_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_serial_operand_tx.sv
// Bench for serial_operand_tx: three builds (N=8 MSB-first, N=8 LSB-first, N=1)
// checked every cycle against a stream-level model, plus directed literal cases.
module tb_serial_operand_tx;

  logic       clk;
  logic [2:0] rst, vld, stall, stop;
  logic [2:0] rdy, sv, sa, sb, sf, sl, dn, bz;
  logic [7:0] a_drv [3];
  logic [7:0] b_drv [3];
  logic [3:0] bs0, bs1;
  logic [0:0] bs2;

  int vectors     = 0;
  int miscompares = 0;
  bit chk_en      = 1'b0;

  // Stream-level model: phase 0 idle, 1 streaming beat k, 2 done pulse.
  int nn  [3] = '{8, 8, 1};
  bit msb [3] = '{1'b1, 1'b0, 1'b1};
  int ph  [3] = '{0, 0, 0};
  int k   [3] = '{0, 0, 0};
  int sent[3] = '{0, 0, 0};
  logic [7:0] opa [3];
  logic [7:0] opb [3];

  serial_operand_tx #(.N(8), .MSB_FIRST(1'b1)) dut_msb (
    .clock(clk), .reset(rst[0]), .in_valid(vld[0]), .in_ready(rdy[0]),
    .a_in(a_drv[0]), .b_in(b_drv[0]), .ser_valid(sv[0]), .ser_a(sa[0]), .ser_b(sb[0]),
    .ser_first(sf[0]), .ser_last(sl[0]), .ser_stall(stall[0]), .ser_stop(stop[0]),
    .done(dn[0]), .bits_sent(bs0), .busy(bz[0]));

  serial_operand_tx #(.N(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clock(clk), .reset(rst[1]), .in_valid(vld[1]), .in_ready(rdy[1]),
    .a_in(a_drv[1]), .b_in(b_drv[1]), .ser_valid(sv[1]), .ser_a(sa[1]), .ser_b(sb[1]),
    .ser_first(sf[1]), .ser_last(sl[1]), .ser_stall(stall[1]), .ser_stop(stop[1]),
    .done(dn[1]), .bits_sent(bs1), .busy(bz[1]));

  serial_operand_tx #(.N(1), .MSB_FIRST(1'b1)) dut_n1 (
    .clock(clk), .reset(rst[2]), .in_valid(vld[2]), .in_ready(rdy[2]),
    .a_in(a_drv[2][0:0]), .b_in(b_drv[2][0:0]), .ser_valid(sv[2]), .ser_a(sa[2]), .ser_b(sb[2]),
    .ser_first(sf[2]), .ser_last(sl[2]), .ser_stall(stall[2]), .ser_stop(stop[2]),
    .done(dn[2]), .bits_sent(bs2), .busy(bz[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int get_bs(input int i);
    case (i)
      0:       return int'(bs0);
      1:       return int'(bs1);
      default: return int'(bs2);
    endcase
  endfunction

  // Model update: consumes the inputs as they stand at the rising edge.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst[i]) begin
        ph[i] = 0; k[i] = 0; sent[i] = 0;
      end else if (ph[i] == 0) begin
        if (vld[i]) begin
          opa[i] = a_drv[i]; opb[i] = b_drv[i]; k[i] = 0; ph[i] = 1;
        end
      end else if (ph[i] == 1) begin
        if (stop[i] || (!stall[i] && k[i] == nn[i] - 1)) begin
          sent[i] = k[i] + (stall[i] ? 0 : 1);
          ph[i]   = 2;
        end else if (!stall[i]) begin
          k[i] = k[i] + 1;
        end
      end else begin
        ph[i] = 0;
      end
    end
  end

  // Compare process: every output of every build, every cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        int  idx;
        bit  s;
        s   = (ph[i] == 1);
        idx = msb[i] ? (nn[i] - 1 - k[i]) : k[i];
        check($sformatf("in_ready[%0d]", i), 32'(rdy[i]), 32'(ph[i] == 0));
        check($sformatf("ser_valid[%0d]", i), 32'(sv[i]), 32'(s));
        check($sformatf("ser_a[%0d]", i), 32'(sa[i]), s ? 32'(opa[i][idx]) : 32'd0);
        check($sformatf("ser_b[%0d]", i), 32'(sb[i]), s ? 32'(opb[i][idx]) : 32'd0);
        check($sformatf("ser_first[%0d]", i), 32'(sf[i]), 32'(s && k[i] == 0));
        check($sformatf("ser_last[%0d]", i), 32'(sl[i]), 32'(s && k[i] == nn[i] - 1));
        check($sformatf("done[%0d]", i), 32'(dn[i]), 32'(ph[i] == 2));
        check($sformatf("busy[%0d]", i), 32'(bz[i]), 32'(ph[i] != 0));
        if (ph[i] == 2) check($sformatf("bits_sent[%0d]", i), 32'(get_bs(i)), 32'(sent[i]));
      end
    end
  end

  // Drives one operand pair and records the transferred beats (first beat ends up
  // in the highest used bit of ga/gb). stall_at/stop_at are beat indices, -1 = never.
  task automatic run_stream(input int i, input logic [7:0] a, input logic [7:0] b,
                            input int stall_at, input int stall_len, input int stop_at,
                            output logic [7:0] ga, output logic [7:0] gb,
                            output int nb, output int shift_cyc, output int bsent,
                            output int f_at, output int l_at);
    int  stalled;
    bit  got_done;
    bit  stall_now;
    ga = '0; gb = '0; nb = 0; shift_cyc = 0; bsent = -1; f_at = -1; l_at = -1;
    stalled = 0; got_done = 1'b0;
    for (int w = 0; w < 20 && !rdy[i]; w++) @(negedge clk);
    vld[i] = 1'b1; a_drv[i] = a; b_drv[i] = b;
    @(negedge clk);
    vld[i] = 1'b0; a_drv[i] = ~a; b_drv[i] = ~b;
    for (int c = 0; c < 40 && !got_done; c++) begin
      if (dn[i]) begin
        got_done = 1'b1;
        bsent    = get_bs(i);
        stall[i] = 1'b0; stop[i] = 1'b0;
      end else begin
        if (sv[i]) begin
          shift_cyc++;
          stall_now = (nb == stall_at) && (stalled < stall_len);
          if (stall_now) stalled++;
          stall[i] = stall_now;
          stop[i]  = (nb == stop_at);
          if (sf[i] && f_at < 0) f_at = nb;
          if (sl[i]) l_at = nb;
          if (!stall_now) begin
            ga = {ga[6:0], sa[i]};
            gb = {gb[6:0], sb[i]};
            nb++;
          end
        end else begin
          stall[i] = 1'b0; stop[i] = 1'b0;
        end
        @(negedge clk);
      end
    end
    if (!got_done) check($sformatf("done_timeout[%0d]", i), 32'd0, 32'd1);
    @(negedge clk);
    check($sformatf("ready_after_done[%0d]", i), 32'(rdy[i]), 32'd1);
  endtask

  logic [7:0] ga, gb;
  int nb, sc, bsn, fa, la, xfers;

  initial begin
    rst = 3'b111; vld = '0; stall = '0; stop = '0;
    for (int i = 0; i < 3; i++) begin a_drv[i] = '0; b_drv[i] = '0; end
    @(negedge clk);
    chk_en = 1'b1;
    check("reset_in_ready", 32'(rdy[0]), 32'd1);
    check("reset_ser_valid", 32'(sv[0]), 32'd0);
    check("reset_done", 32'(dn[0]), 32'd0);
    check("reset_bits_sent", 32'(bs0), 32'd0);
    check("reset_busy", 32'(bz[0]), 32'd0);
    @(negedge clk);
    rst = '0;
    @(negedge clk);

    // Plain MSB-first stream.
    run_stream(0, 8'hA5, 8'h3C, -1, 0, -1, ga, gb, nb, sc, bsn, fa, la);
    check("basic_a_seq", 32'(ga), 32'hA5);
    check("basic_b_seq", 32'(gb), 32'h3C);
    check("basic_bits_sent", 32'(bsn), 32'd8);
    check("basic_shift_cycles", 32'(sc), 32'd8);
    check("basic_first_at", 32'(fa), 32'd0);
    check("basic_last_at", 32'(la), 32'd7);

    // Two-cycle stall on the third beat.
    run_stream(0, 8'hA5, 8'h3C, 2, 2, -1, ga, gb, nb, sc, bsn, fa, la);
    check("stall_a_seq", 32'(ga), 32'hA5);
    check("stall_b_seq", 32'(gb), 32'h3C);
    check("stall_shift_cycles", 32'(sc), 32'd10);
    check("stall_bits_sent", 32'(bsn), 32'd8);

    // Early stop on the first beat.
    run_stream(0, 8'hA5, 8'h3C, -1, 0, 0, ga, gb, nb, sc, bsn, fa, la);
    check("stop_bits_sent", 32'(bsn), 32'd1);
    check("stop_shift_cycles", 32'(sc), 32'd1);
    check("stop_a_bit", 32'(ga), 32'd1);
    check("stop_b_bit", 32'(gb), 32'd0);

    // LSB-first build.
    run_stream(1, 8'hA5, 8'h3C, -1, 0, -1, ga, gb, nb, sc, bsn, fa, la);
    check("lsb_a_seq", 32'(ga), 32'hA5);
    check("lsb_b_seq", 32'(gb), 32'h3C);
    check("lsb_bits_sent", 32'(bsn), 32'd8);

    // Reset while beat 4 is presented, then a fresh stream.
    vld[0] = 1'b1; a_drv[0] = 8'hA5; b_drv[0] = 8'h3C;
    @(negedge clk);
    vld[0] = 1'b0;
    xfers = 0;
    for (int c = 0; c < 20 && xfers < 3; c++) begin
      if (sv[0]) xfers++;
      @(negedge clk);
    end
    check("pre_reset_valid", 32'(sv[0]), 32'd1);
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    check("midreset_ser_valid", 32'(sv[0]), 32'd0);
    check("midreset_in_ready", 32'(rdy[0]), 32'd1);
    for (int c = 0; c < 3; c++) begin
      check("midreset_no_done", 32'(dn[0]), 32'd0);
      @(negedge clk);
    end
    run_stream(0, 8'hFF, 8'h00, -1, 0, -1, ga, gb, nb, sc, bsn, fa, la);
    check("after_reset_a_seq", 32'(ga), 32'hFF);
    check("after_reset_b_seq", 32'(gb), 32'h00);
    check("after_reset_bits_sent", 32'(bsn), 32'd8);

    // Single-bit build.
    run_stream(2, 8'h01, 8'h00, -1, 0, -1, ga, gb, nb, sc, bsn, fa, la);
    check("n1_a_bit", 32'(ga), 32'd1);
    check("n1_b_bit", 32'(gb), 32'd0);
    check("n1_bits_sent", 32'(bsn), 32'd1);
    check("n1_first_at", 32'(fa), 32'd0);
    check("n1_last_at", 32'(la), 32'd0);

    // in_valid held with a changing operand; the model tracks which pairs land.
    vld[2] = 1'b1;
    for (int c = 0; c < 12; c++) begin
      a_drv[2] = 8'(c & 1); b_drv[2] = 8'((c >> 1) & 1);
      @(negedge clk);
    end
    vld[2] = 1'b0;

    // Randomized traffic on all three builds at once.
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        rst[i]   = ($urandom_range(0, 99) == 0);
        vld[i]   = ($urandom_range(0, 2) != 0);
        a_drv[i] = 8'($urandom);
        b_drv[i] = 8'($urandom);
        stall[i] = ($urandom_range(0, 3) == 0);
        stop[i]  = ($urandom_range(0, 19) == 0);
      end
    end
    @(negedge clk);
    rst = '0; vld = '0; stall = '0; stop = '0;
    repeat (12) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
